// File: rtl/genie_mem_if.sv
// genie_mem_if: request/response bus between the data loaders and the memory responder.
interface genie_mem_if #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12
);
    logic                  wvalid;
    logic                  wready;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_W-1:0]     raddr;
    logic [DATA_W-1:0]     rdata;
    logic                  stall;
    logic                  bd_we;
    logic [DEPTH_LOG2-1:0] bd_addr;
    logic [DATA_W-1:0]     bd_data;
    logic                  oob;
    logic [31:0]           rd_count;
    logic [31:0]           wr_count;
    modport slave (
        input  wvalid, waddr, wdata, rvalid, raddr, stall, bd_we, bd_addr, bd_data,
        output wready, rready, rdata, oob, rd_count, wr_count
    );
    modport master (
        output wvalid, waddr, wdata, rvalid, raddr, stall, bd_we, bd_addr, bd_data,
        input  wready, rready, rdata, oob, rd_count, wr_count
    );
endinterface

// File: rtl/genie_mem_responder.sv
// genie_mem_responder: single-outstanding word memory model with programmable latency and stall injection.
module genie_mem_responder #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LAT     = 3,
    parameter int WR_LAT     = 1
) (
    input logic        clk,
    input logic        rst,
    genie_mem_if.slave bus
);
    localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  oob_q;
    logic [31:0]           rd_count_q;
    logic [31:0]           wr_count_q;
    logic [DATA_W-1:0]     mem_q [2**DEPTH_LOG2];
    logic                  done;
    logic                  rd_ack;
    logic                  wr_ack;
    // Ack is gated by stall and by reset so an aborted write neither acks nor commits
    assign done         = !rst && !bus.stall && cnt_q == '0;
    assign rd_ack       = done && state_q == RD_WAIT;
    assign wr_ack       = done && state_q == WR_WAIT;
    assign bus.rready   = rd_ack;
    assign bus.wready   = wr_ack;
    assign bus.rdata    = rd_ack ? mem_q[addr_q] : '0;
    assign bus.oob      = oob_q;
    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            oob_q      <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.wvalid) begin
                        addr_q  <= bus.waddr[DEPTH_LOG2-1:0];
                        data_q  <= bus.wdata;
                        cnt_q   <= CNT_W'(WR_LAT - 1);
                        oob_q   <= oob_q | (|bus.waddr[ADDR_W-1:DEPTH_LOG2]);
                        state_q <= WR_WAIT;
                    end else if (bus.rvalid) begin
                        addr_q     <= bus.raddr[DEPTH_LOG2-1:0];
                        cnt_q      <= CNT_W'(RD_LAT - 1);
                        oob_q      <= oob_q | (|bus.raddr[ADDR_W-1:DEPTH_LOG2]);
                        rd_count_q <= rd_count_q + 32'd1;
                        state_q    <= RD_WAIT;
                    end
                end
                default: begin
                    if (!bus.stall) begin
                        state_q <= cnt_q == '0 ? IDLE : state_q;
                        cnt_q   <= cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                    end
                    if (wr_ack) wr_count_q <= wr_count_q + 32'd1;
                end
            endcase
        end
    end
    // Protocol commit is assigned last so it wins over a same-address backdoor write
    always_ff @(posedge clk) begin
        if (bus.bd_we) mem_q[bus.bd_addr] <= bus.bd_data;
        if (wr_ack) mem_q[addr_q] <= data_q;
    end
endmodule
